// File: rtl/ddr3_command_responder.sv
// DDR3 device-side responder: decodes commands, tracks open rows per bank, stores write bursts
// in an internal array and returns read bursts at CAS latency. Data is one beat per clk.
`timescale 1ns/1ps
module ddr3_command_responder #(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int CL                    = 5,
  parameter int CWL                   = 5,
  parameter int BURST_LENGTH          = 4,
  parameter int ROW_BITS              = 2,
  parameter int COL_BITS              = 5
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  ck_en,
  input  logic                                  cs_n,
  input  logic                                  ras_n,
  input  logic                                  cas_n,
  input  logic                                  we_n,
  input  logic [ADDRESS_BITWIDTH-1:0]           address,
  input  logic [BANK_ADDRESS_BITWIDTH-1:0]      bank_address,
  input  logic [DQ_BITWIDTH-1:0]                dq_in,
  input  logic [DQ_BITWIDTH/8-1:0]              dm,
  output logic [DQ_BITWIDTH-1:0]                dq_out,
  output logic                                  dq_oe,
  output logic                                  dqs_out,
  output logic [2**BANK_ADDRESS_BITWIDTH-1:0]   bank_open,
  output logic                                  err_protocol,
  output logic                                  err_collision,
  output logic                                  err_cke
);
  localparam int NB    = 2**BANK_ADDRESS_BITWIDTH;
  localparam int LANES = DQ_BITWIDTH/8;
  localparam int BLW   = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  localparam int IDX_W = BANK_ADDRESS_BITWIDTH + ROW_BITS + COL_BITS;
  localparam logic [3:0] BL4 = 4'(BURST_LENGTH);

  typedef struct packed {
    logic                             vld;
    logic [BANK_ADDRESS_BITWIDTH-1:0] bank;
    logic [ROW_BITS-1:0]              row;
    logic [COL_BITS-1:0]              col;
  } entry_t;

  logic [NB-1:0]          open_q, open_d;
  logic [ROW_BITS-1:0]    row_q [NB];
  entry_t                 rd_pipe_q [CL];
  entry_t                 wr_pipe_q [CWL];
  entry_t                 burst_q, burst_d, rd_push, wr_push, rd_exit, wr_exit;
  logic                   burst_rd_q, burst_rd_d;
  logic [3:0]             rem_q, rem_d;
  logic                   dq_oe_q, dq_oe_d, dqs_q, dqs_d;
  logic                   err_protocol_q, err_protocol_d, err_collision_q, err_cke_q;
  logic                   row_we;
  logic [DQ_BITWIDTH-1:0] mem [2**IDX_W];
  logic [DQ_BITWIDTH-1:0] rd_data_q;

  logic cmd_en, cmd_act, cmd_rd, cmd_wr, cmd_pre, cmd_ref, a10, bank_is_open;
  assign cmd_en       = ck_en & ~cs_n;
  assign cmd_act      = cmd_en && ({ras_n, cas_n, we_n} == 3'b011);
  assign cmd_rd       = cmd_en && ({ras_n, cas_n, we_n} == 3'b101);
  assign cmd_wr       = cmd_en && ({ras_n, cas_n, we_n} == 3'b100);
  assign cmd_pre      = cmd_en && ({ras_n, cas_n, we_n} == 3'b010);
  assign cmd_ref      = cmd_en && ({ras_n, cas_n, we_n} == 3'b001);
  assign a10          = address[10];
  assign bank_is_open = open_q[bank_address];

  // The row travels with the pipe entry so auto-precharge cannot disturb the burst address.
  always_comb begin
    rd_push      = '{vld: 1'b0, bank: bank_address, row: row_q[bank_address],
                     col: address[COL_BITS-1:0]};
    wr_push      = rd_push;
    rd_push.vld  = cmd_rd & bank_is_open;
    wr_push.vld  = cmd_wr & bank_is_open;
  end

  always_comb begin
    open_d         = open_q;
    err_protocol_d = err_protocol_q;
    row_we         = 1'b0;
    if (cmd_act) begin
      if (bank_is_open) err_protocol_d = 1'b1;
      else begin
        open_d[bank_address] = 1'b1;
        row_we               = 1'b1;
      end
    end
    if (cmd_rd || cmd_wr) begin
      if (!bank_is_open) err_protocol_d = 1'b1;
      else if (a10)      open_d[bank_address] = 1'b0;
    end
    if (cmd_pre) begin
      if (a10) open_d = '0;
      else     open_d[bank_address] = 1'b0;
    end
    if (cmd_ref && (|open_q)) err_protocol_d = 1'b1;
  end

  // rem_q counts receiver sample edges still owed to the current burst, so a new burst may
  // start on the edge the count reaches zero and both directions stream at BL spacing.
  logic busy, start_rd, start_wr, collide, pipes_busy;
  logic [3:0] rd_beat, wr_beat;
  assign rd_exit  = rd_pipe_q[CL-1];
  assign wr_exit  = wr_pipe_q[CWL-1];
  assign busy     = (rem_q != 4'd0);
  assign start_rd = rd_exit.vld & ~busy;
  assign start_wr = wr_exit.vld & ~busy & ~rd_exit.vld;
  assign collide  = (rd_exit.vld & busy) | (wr_exit.vld & (busy | rd_exit.vld));
  assign rd_beat  = BL4 - rem_q + 4'd1;
  assign wr_beat  = BL4 - rem_q;

  always_comb begin
    pipes_busy = 1'b0;
    for (int i = 0; i < CL; i++)  pipes_busy = pipes_busy | rd_pipe_q[i].vld;
    for (int i = 0; i < CWL; i++) pipes_busy = pipes_busy | wr_pipe_q[i].vld;
  end

  function automatic logic [IDX_W-1:0] beat_index(input entry_t e, input logic [3:0] k);
    logic [COL_BITS-1:0] c;
    c          = e.col;
    c[BLW-1:0] = e.col[BLW-1:0] + k[BLW-1:0];
    return {e.bank, e.row, c};
  endfunction

  always_comb begin
    rem_d      = busy ? rem_q - 4'd1 : 4'd0;
    burst_d    = burst_q;
    burst_rd_d = burst_rd_q;
    dq_oe_d    = 1'b0;
    dqs_d      = 1'b0;
    if (start_rd || start_wr) begin
      rem_d      = BL4;
      burst_d    = start_rd ? rd_exit : wr_exit;
      burst_rd_d = start_rd;
    end
    if (start_rd) begin
      dq_oe_d = 1'b1;
      dqs_d   = 1'b1;
    end else if (burst_rd_q && rem_q > 4'd1) begin
      dq_oe_d = 1'b1;
      dqs_d   = ~rd_beat[0];
    end
  end

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             wr_en;
  assign rd_idx = start_rd ? beat_index(rd_exit, 4'd0) : beat_index(burst_q, rd_beat);
  assign wr_idx = beat_index(burst_q, wr_beat);
  assign wr_en  = busy & ~burst_rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < LANES; l++)
        if (!dm[l]) mem[wr_idx][8*l +: 8] <= dq_in[8*l +: 8];
    end
    rd_data_q <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      open_q          <= '0;
      for (int b = 0; b < NB; b++)  row_q[b]     <= '0;
      for (int i = 0; i < CL; i++)  rd_pipe_q[i] <= '0;
      for (int i = 0; i < CWL; i++) wr_pipe_q[i] <= '0;
      burst_q         <= '0;
      burst_rd_q      <= 1'b0;
      rem_q           <= 4'd0;
      dq_oe_q         <= 1'b0;
      dqs_q           <= 1'b0;
      err_protocol_q  <= 1'b0;
      err_collision_q <= 1'b0;
      err_cke_q       <= 1'b0;
    end else begin
      open_q <= open_d;
      if (row_we) row_q[bank_address] <= address[ROW_BITS-1:0];
      rd_pipe_q[0] <= rd_push;
      for (int i = 1; i < CL; i++)  rd_pipe_q[i] <= rd_pipe_q[i-1];
      wr_pipe_q[0] <= wr_push;
      for (int i = 1; i < CWL; i++) wr_pipe_q[i] <= wr_pipe_q[i-1];
      burst_q         <= burst_d;
      burst_rd_q      <= burst_rd_d;
      rem_q           <= rem_d;
      dq_oe_q         <= dq_oe_d;
      dqs_q           <= dqs_d;
      err_protocol_q  <= err_protocol_d;
      err_collision_q <= err_collision_q | collide;
      err_cke_q       <= err_cke_q | (~ck_en & (busy | pipes_busy));
    end
  end

  assign dq_out        = dq_oe_q ? rd_data_q : '0;
  assign dq_oe         = dq_oe_q;
  assign dqs_out       = dqs_q;
  assign bank_open     = open_q;
  assign err_protocol  = err_protocol_q;
  assign err_collision = err_collision_q;
  assign err_cke       = err_cke_q;

  logic unused_bits;
  assign unused_bits = ^{address, burst_q.vld, rd_beat, wr_beat};
endmodule

// File: tb/tb_ddr3_command_responder.sv
// Directed bench for ddr3_command_responder; read beats are checked against a scoreboard queue
// filled when each RD is issued.
`timescale 1ns/1ps
module tb_ddr3_command_responder;
  localparam int CL = 5, CWL = 5, BL = 4;
  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                         C_PRE = 3'b010, C_REF = 3'b001;

  logic        clk = 1'b0;
  logic        reset_n, ck_en, cs_n, ras_n, cas_n, we_n;
  logic [14:0] address;
  logic [2:0]  bank_address;
  logic [15:0] dq_in, dq_out;
  logic [1:0]  dm;
  logic        dq_oe, dqs_out, err_protocol, err_collision, err_cke;
  logic [7:0]  bank_open;

  always #5 clk = ~clk;

  ddr3_command_responder #(.ADDRESS_BITWIDTH(15), .BANK_ADDRESS_BITWIDTH(3), .DQ_BITWIDTH(16),
                           .CL(CL), .CWL(CWL), .BURST_LENGTH(BL), .ROW_BITS(2), .COL_BITS(5)) dut (
    .clk(clk), .reset_n(reset_n), .ck_en(ck_en), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .address(address), .bank_address(bank_address), .dq_in(dq_in), .dm(dm),
    .dq_out(dq_out), .dq_oe(dq_oe), .dqs_out(dqs_out), .bank_open(bank_open),
    .err_protocol(err_protocol), .err_collision(err_collision), .err_cke(err_cke));

  int vectors = 0, miscompares = 0, beats_seen = 0;
  typedef struct {logic [15:0] d; logic s;} beat_t;
  beat_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (reset_n === 1'b1 && dq_oe === 1'b1) begin
      beats_seen++;
      if (exp_q.size() == 0) check("beat_without_pending_read", 32'(exp_q.size()), 32'd1);
      else begin
        b = exp_q.pop_front();
        check("dq_out", 32'(dq_out), 32'(b.d));
        check("dqs_out", 32'(dqs_out), 32'(b.s));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [2:0] ba, input logic [14:0] a,
                     input string name);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; bank_address = ba; address = a;
    @(posedge clk); #1;
    cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
    $display("txn %s bank %0d addr %0h", name, ba, a);
  endtask

  task automatic expect_burst(input logic [63:0] data);
    for (int k = 0; k < BL; k++) exp_q.push_back('{d: data[16*k +: 16], s: (k % 2 == 0)});
  endtask

  task automatic read(input logic [2:0] ba, input logic [14:0] col, input logic [63:0] data);
    cmd(C_RD, ba, col, "RD");
    expect_burst(data);
  endtask

  task automatic write(input logic [2:0] ba, input logic [14:0] col, input logic [63:0] data,
                       input logic [7:0] dms);
    cmd(C_WR, ba, col, "WR");
    repeat (CWL) @(posedge clk);
    #1;
    for (int k = 0; k < BL; k++) begin
      dq_in = data[16*k +: 16]; dm = dms[2*k +: 2];
      @(posedge clk); #1;
    end
    dm = 2'b11; dq_in = 16'h0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; cs_n = 1'b1; ck_en = 1'b1;
    exp_q.delete();
    idle(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    reset_n = 1'b0; ck_en = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
    address = '0; bank_address = '0; dq_in = '0; dm = 2'b11;
    idle(2);
    check("reset_dq_oe", 32'(dq_oe), 32'd0);
    check("reset_dq_out", 32'(dq_out), 32'd0);
    check("reset_dqs", 32'(dqs_out), 32'd0);
    check("reset_bank_open", 32'(bank_open), 32'd0);
    check("reset_errs", 32'({err_protocol, err_collision, err_cke}), 32'd0);
    reset_n = 1'b1;

    // Write then read, with latency checks around the first beat and the oe fall.
    cmd(C_ACT, 3'd2, 15'd1, "ACT");
    check("act_bank_open", 32'(bank_open), 32'h04);
    write(3'd2, 15'd8, 64'h4444_3333_2222_1111, 8'h00);
    read(3'd2, 15'd8, 64'h4444_3333_2222_1111);
    repeat (CL-1) @(posedge clk);
    @(negedge clk); check("oe_before_cl", 32'(dq_oe), 32'd0);
    @(negedge clk); check("oe_at_cl", 32'(dq_oe), 32'd1);
    repeat (BL) @(negedge clk); check("oe_after_burst", 32'(dq_oe), 32'd0);
    idle(2);
    check("wr_rd_drained", 32'(exp_q.size()), 32'd0);
    check("wr_rd_errs", 32'({err_protocol, err_collision, err_cke}), 32'd0);

    // Wrap order and byte mask.
    write(3'd2, 15'd8, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00);
    write(3'd2, 15'd10, 64'h0000_0000_0000_5555, 8'hFE);
    read(3'd2, 15'd8, 64'hAAAA_AA55_AAAA_AAAA);
    idle(CL + BL + 2);
    read(3'd2, 15'd10, 64'hAAAA_AAAA_AAAA_AA55);
    idle(CL + BL + 2);
    check("mask_drained", 32'(exp_q.size()), 32'd0);
    check("mask_errs", 32'({err_protocol, err_collision, err_cke}), 32'd0);

    // Closed-bank read, then ACT to an open bank.
    b0 = beats_seen;
    cmd(C_RD, 3'd5, 15'd8, "RD");
    idle(CL + BL + 2);
    check("closed_rd_err_protocol", 32'(err_protocol), 32'd1);
    check("closed_rd_no_beats", 32'(beats_seen - b0), 32'd0);
    do_reset;
    check("reset_clears_err_protocol", 32'(err_protocol), 32'd0);
    cmd(C_ACT, 3'd2, 15'd1, "ACT");
    check("first_act_ok", 32'(err_protocol), 32'd0);
    cmd(C_ACT, 3'd2, 15'd1, "ACT");
    check("double_act_err", 32'(err_protocol), 32'd1);

    // Two reads two cycles apart: first burst intact, second dropped.
    do_reset;
    cmd(C_ACT, 3'd2, 15'd1, "ACT");
    b0 = beats_seen;
    read(3'd2, 15'd8, 64'hAAAA_AA55_AAAA_AAAA);
    idle(1);
    cmd(C_RD, 3'd2, 15'd8, "RD");
    idle(CL + BL + 4);
    check("collision_flag", 32'(err_collision), 32'd1);
    check("collision_beats", 32'(beats_seen - b0), 32'd4);
    check("collision_drained", 32'(exp_q.size()), 32'd0);
    check("collision_no_protocol", 32'(err_protocol), 32'd0);

    // Precharge-all and refresh.
    do_reset;
    cmd(C_ACT, 3'd0, 15'd0, "ACT");
    cmd(C_ACT, 3'd3, 15'd2, "ACT");
    cmd(C_ACT, 3'd7, 15'd3, "ACT");
    check("three_banks_open", 32'(bank_open), 32'h89);
    cmd(C_PRE, 3'd0, 15'h0400, "PREA");
    check("prea_closes_all", 32'(bank_open), 32'h00);
    cmd(C_REF, 3'd0, 15'd0, "REF");
    check("ref_closed_ok", 32'(err_protocol), 32'd0);
    cmd(C_ACT, 3'd1, 15'd0, "ACT");
    cmd(C_REF, 3'd0, 15'd0, "REF");
    check("ref_open_err", 32'(err_protocol), 32'd1);

    // Reset asserted while beat 1 is on the bus.
    do_reset;
    cmd(C_ACT, 3'd2, 15'd1, "ACT");
    b0 = beats_seen;
    cmd(C_RD, 3'd2, 15'd8, "RD");
    exp_q.push_back('{d: 16'hAAAA, s: 1'b1});
    repeat (CL + 1) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_dq_oe", 32'(dq_oe), 32'd0);
    check("midrst_dq_out", 32'(dq_out), 32'd0);
    check("midrst_dqs", 32'(dqs_out), 32'd0);
    check("midrst_errs", 32'({err_protocol, err_collision, err_cke}), 32'd0);
    check("midrst_bank_open", 32'(bank_open), 32'd0);
    check("midrst_beats", 32'(beats_seen - b0), 32'd1);
    check("midrst_drained", 32'(exp_q.size()), 32'd0);
    idle(2);
    reset_n = 1'b1;
    b0 = beats_seen;
    cmd(C_RD, 3'd2, 15'd8, "RD");
    idle(CL + BL + 2);
    check("post_reset_rd_err", 32'(err_protocol), 32'd1);
    check("post_reset_no_beats", 32'(beats_seen - b0), 32'd0);

    // CKE dropped while a read is in the pipe; the burst still completes.
    cmd(C_ACT, 3'd2, 15'd1, "ACT");
    read(3'd2, 15'd8, 64'hAAAA_AA55_AAAA_AAAA);
    ck_en = 1'b0;
    idle(1);
    ck_en = 1'b1;
    idle(CL + BL + 2);
    check("cke_err", 32'(err_cke), 32'd1);
    check("cke_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
